branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
// Consumer side of the branch comparator interface. Drives o_br_un to the comparator and
// samples its o_br_less/o_br_equal flags. Decodes the RV32I branch condition from funct3.
// Computes the next-PC redirect for B-type branches and JAL/JALR, and raises a misaligned-target trap.
// Keeps saturating branch performance counters. Sits between decode/comparator and the PC register.
// PARAMETERS
// CNT_W   32   width of the saturating counters o_br_total_cnt / o_br_taken_cnt
// PORTS
// i_clk           in   1      clock, rising edge
// i_rst_n         in   1      asynchronous reset, active-low
// i_valid         in   1      request valid; accepted when i_valid && o_ready
// o_ready         out  1      high only in IDLE
// i_is_branch     in   1      conditional B-type instruction
// i_is_jal        in   1      JAL
// i_is_jalr       in   1      JALR (at most one of the three kinds is high)
// i_funct3        in   3      branch condition
// i_pc            in   32     PC of the instruction
// i_imm           in   32     sign-extended immediate
// i_rs1_data      in   32     JALR base register
// o_br_un         out  1      to comparator: = i_funct3[1] (combinational, unsigned compare)
// i_br_less       in   1      comparator flag, valid in the accept cycle
// i_br_equal      in   1      comparator flag, valid in the accept cycle
// o_redirect      out  1      one-cycle pulse: take o_target
// o_target        out  32     redirect target PC
// o_link          out  32     pc+4 for JAL/JALR rd write, else 0
// o_illegal       out  1      one-cycle pulse: funct3 is 010 or 011 on a branch
// o_misalign      out  1      level: target[1:0]!=0; held until i_trap_ack
// i_trap_ack      in   1      releases EXCEPT
// i_cnt_clr       in   1      synchronous clear of both counters
// o_br_total_cnt  out  CNT_W  accepted conditional branches
// o_br_taken_cnt  out  CNT_W  taken conditional branches
// BEHAVIOUR
// - Reset: state=IDLE, o_ready=1. All other outputs and both counters are 0. Reset mid-operation drops the pending request.
// - FSM IDLE -> RESULT on accept. RESULT -> IDLE after 1 cycle, or RESULT -> EXCEPT if misaligned.
//   EXCEPT -> IDLE on i_trap_ack (ack sampled only in EXCEPT).
// - Accept cycle: register the decision, target, link and the taken/illegal/misalign flags.
//   All outputs are valid in the RESULT cycle (latency 1, throughput 1 per 2 cycles).
// - Taken: 000 eq; 001 !eq; 100/110 less; 101/111 !less; 010/011 never taken and o_illegal=1.
//   JAL/JALR are always taken.
// - Target arithmetic is 32-bit with wrap-around, no carry out:
//   branch/JAL = pc+imm; JALR = (rs1+imm) & ~32'h1.
// - Misalign: checked only when taken, on target[1:0]!=0. Then o_redirect=0, o_misalign=1, enter EXCEPT.
//   o_misalign stays 1 through EXCEPT and clears in the cycle after i_trap_ack.
// - Counters update in the accept cycle, conditional branches only (illegal funct3 included in total).
//   Both counters saturate at all-ones. i_cnt_clr wins over a simultaneous increment.
// - o_redirect and o_illegal are 0 outside RESULT. o_link holds its value only during RESULT.
// - Not taken: o_redirect=0, o_target=pc+4.
// TESTING
// - BEQ, pc=0x100, imm=0x20, br_equal=1 -> next cycle o_redirect=1, o_target=0x120; total=1, taken=1.
// - BLTU funct3=110 -> o_br_un=1 in the accept cycle. br_less=0 -> o_redirect=0, o_target=pc+4.
// - JALR rs1=0x1001, imm=1 -> target 0x1002 -> o_misalign=1, o_ready=0.
//   Stays until i_trap_ack; o_ready=1 one cycle after the ack.
// - funct3=010 branch -> o_illegal pulse, no redirect, total increments, taken does not.
// - CNT_W=4: 17 taken branches -> taken=4'hF. i_cnt_clr asserted with an accept -> both counters 0.
// - Assert i_rst_n=0 asynchronously in RESULT and in EXCEPT -> immediately IDLE, outputs 0, o_ready=1.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch/jump resolver: decodes the RV32I branch condition, computes the next-PC redirect and link,
// traps misaligned targets and keeps saturating branch performance counters.
module branch_resolver #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1_data,
  output logic             o_br_un,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_redirect,
  output logic [31:0]      o_target,
  output logic [31:0]      o_link,
  output logic             o_illegal,
  output logic             o_misalign,
  input  logic             i_trap_ack,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_br_total_cnt,
  output logic [CNT_W-1:0] o_br_taken_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESULT = 2'd1,
    EXCEPT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_redirect;
  logic             r_illegal;
  logic             r_misalign;
  logic [XLEN-1:0]  r_target;
  logic [XLEN-1:0]  r_link;
  logic [CNT_W-1:0] r_total_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_accept;
  logic             w_cond;
  logic             w_illegal;
  logic             w_taken;
  logic             w_misalign;
  logic             w_redirect;
  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_jump_tgt;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_link;

  assign w_accept = i_valid && (r_state == IDLE);
  assign o_br_un  = i_funct3[1];

  // Branch condition from the comparator flags; 010/011 are reserved and never taken.
  always_comb begin
    w_cond = 1'b0;
    unique case (i_funct3)
      3'b000:         w_cond = i_br_equal;
      3'b001:         w_cond = !i_br_equal;
      3'b100, 3'b110: w_cond = i_br_less;
      3'b101, 3'b111: w_cond = !i_br_less;
      default:        w_cond = 1'b0;
    endcase
  end

  assign w_illegal  = i_is_branch && (i_funct3[2:1] == 2'b01);
  assign w_taken    = i_is_jal || i_is_jalr || (i_is_branch && w_cond);
  assign w_seq_pc   = i_pc + XLEN'(4);
  assign w_jump_tgt = i_is_jalr ? ((i_rs1_data + i_imm) & ~XLEN'(1)) : (i_pc + i_imm);
  assign w_target   = w_taken ? w_jump_tgt : w_seq_pc;
  assign w_misalign = w_taken && (w_target[1:0] != 2'b00);
  assign w_redirect = w_taken && !w_misalign;
  assign w_link     = (i_is_jal || i_is_jalr) ? w_seq_pc : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RESULT;
      RESULT:  w_state_nxt = r_misalign ? EXCEPT : IDLE;
      EXCEPT:  if (i_trap_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result registers: loaded on accept, pulses dropped after RESULT, misalign held until ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
      r_misalign <= 1'b0;
      r_target   <= '0;
      r_link     <= '0;
    end else if (w_accept) begin
      r_redirect <= w_redirect;
      r_illegal  <= w_illegal;
      r_misalign <= w_misalign;
      r_target   <= w_target;
      r_link     <= w_link;
    end else if (r_state == RESULT) begin
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
      r_link     <= '0;
    end else if ((r_state == EXCEPT) && i_trap_ack) begin
      r_misalign <= 1'b0;
    end
  end

  // Saturating performance counters; clear has priority over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_total_cnt <= '0;
      r_taken_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_total_cnt <= '0;
      r_taken_cnt <= '0;
    end else if (w_accept && i_is_branch) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + CNT_W'(1);
      if (w_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign o_ready        = (r_state == IDLE);
  assign o_redirect     = r_redirect;
  assign o_illegal      = r_illegal;
  assign o_misalign     = r_misalign;
  assign o_target       = r_target;
  assign o_link         = r_link;
  assign o_br_total_cnt = r_total_cnt;
  assign o_br_taken_cnt = r_taken_cnt;

endmodule
